// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant bundle between the four requesters and the mux select controller.
interface mux4_rr_arbiter_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       s1;
    logic       s0;
    logic       busy;

    modport master (output req, input gnt, s1, s0, busy);
    modport slave  (input req, output gnt, s1, s0, busy);
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select lines of a shared 4:1 mux.
// Optional hold-time limit with forced rotation: define MUX_ARB_TIMEOUT_EN.
module mux4_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    mux4_rr_arbiter_if.slave    bus
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state_q, state_d;
    logic [3:0]         gnt_q, gnt_d;
    logic [1:0]         sel_q, sel_d;
    logic [1:0]         ptr_q, ptr_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [3:0]         others_c;
    logic               own_req_c;
    logic               any_req_c;
    logic               any_oth_c;
    logic [1:0]         win_all_c;
    logic [1:0]         win_oth_c;
    logic               timeout_c;

    if (MAX_HOLD < 2 || MAX_HOLD > (1 << CNT_W)) begin : g_bad_max_hold
        $error("mux4_rr_arbiter: MAX_HOLD outside 2..2**CNT_W");
    end

    // First asserted index scanning start, start+1, ... modulo 4.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [1:0] idx;
        logic       found;
        rr_pick = start;
        found   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = start + 2'(i);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    always_comb begin
        own_req_c = bus.req[sel_q];
        others_c  = bus.req & ~(4'b0001 << sel_q);
        any_req_c = |bus.req;
        any_oth_c = |others_c;
        win_all_c = rr_pick(bus.req, ptr_q);
        win_oth_c = rr_pick(others_c, ptr_q);
`ifdef MUX_ARB_TIMEOUT_EN
        timeout_c = (cnt_q == CNT_W'(MAX_HOLD - 1));
`else
        timeout_c = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req_c) state_d = GRANT;
            GRANT:   if (!own_req_c && !any_oth_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next grant/select/pointer/counter; a handoff excludes the current owner from the scan.
    always_comb begin
        gnt_d  = gnt_q;
        sel_d  = sel_q;
        ptr_d  = ptr_q;
        busy_d = busy_q;
        cnt_d  = cnt_q;
        case (state_q)
            IDLE: begin
                if (any_req_c) begin
                    gnt_d  = 4'b0001 << win_all_c;
                    sel_d  = win_all_c;
                    ptr_d  = win_all_c + 2'd1;
                    busy_d = 1'b1;
                    cnt_d  = '0;
                end
            end
            GRANT: begin
                if (own_req_c && !timeout_c) begin
                    cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
                end else if (any_oth_c) begin
                    gnt_d = 4'b0001 << win_oth_c;
                    sel_d = win_oth_c;
                    ptr_d = win_oth_c + 2'd1;
                    cnt_d = '0;
                end else if (own_req_c) begin
                    cnt_d = '0;
                end else begin
                    gnt_d  = 4'b0000;
                    busy_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q  <= 4'b0000;
            sel_q  <= 2'd0;
            ptr_q  <= 2'd0;
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            gnt_q  <= gnt_d;
            sel_q  <= sel_d;
            ptr_q  <= ptr_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.s1   = sel_q[1];
    assign bus.s0   = sel_q[0];
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: per-cycle reference model plus directed literal checks.
module tb_mux4_rr_arbiter;
    localparam int unsigned MAX_HOLD = 8;
    localparam int unsigned CNT_W    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mux4_rr_arbiter_if bus ();

    mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int         owner;   // -1 when idle
        int         ptr;
        int         hold;
        logic [1:0] sel;
    } mstate_t;

    mstate_t m;

    function automatic int first_from(input logic [3:0] r, input int start);
        for (int i = 0; i < 4; i++) begin
            if (r[(start + i) % 4]) return (start + i) % 4;
        end
        return -1;
    endfunction

    function automatic mstate_t step(input mstate_t s, input logic [3:0] r);
        mstate_t    n;
        logic [3:0] mask;
        int         o;
        n = s;
        if (s.owner < 0) begin
            if (r != 4'b0000) begin
                n.owner = first_from(r, s.ptr);
                n.hold  = 0;
            end
        end else if (r[s.owner]) begin
            n.hold = (s.hold < 15) ? s.hold + 1 : 15;
`ifdef MUX_ARB_TIMEOUT_EN
            if (s.hold == int'(MAX_HOLD) - 1) begin
                mask   = 4'b0001 << s.owner;
                o      = first_from(r & ~mask, s.ptr);
                n.hold = 0;
                if (o >= 0) n.owner = o;
            end
`endif
        end else begin
            n.owner = (r != 4'b0000) ? first_from(r, s.ptr) : -1;
            n.hold  = 0;
        end
        if (n.owner >= 0 && n.owner != s.owner) begin
            n.ptr = (n.owner + 1) % 4;
            n.sel = 2'(n.owner);
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= '{owner: -1, ptr: 0, hold: 0, sel: 2'b00};
        else     m <= step(m, bus.req);
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic lit(input string name, input logic [3:0] g, input logic [1:0] s, input logic b);
        chk({name, ".gnt"},  bus.gnt, g);
        chk({name, ".sel"},  {2'b00, bus.s1, bus.s0}, {2'b00, s});
        chk({name, ".busy"}, {3'b000, bus.busy}, {3'b000, b});
    endtask

    // Every cycle out of reset the DUT must match the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("model.gnt",  bus.gnt, (m.owner < 0) ? 4'b0000 : (4'b0001 << m.owner));
            chk("model.sel",  {2'b00, bus.s1, bus.s0}, {2'b00, m.sel});
            chk("model.busy", {3'b000, bus.busy}, {3'b000, (m.owner >= 0)});
        end
    end

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] r;
        bus.req = 4'b0000;
        repeat (2) @(negedge clk);
        lit("reset", 4'b0000, 2'b00, 1'b0);
        rst = 1'b0;

        // Single request, then release
        @(negedge clk) bus.req = 4'b0100;
        @(negedge clk) lit("single_grant", 4'b0100, 2'b10, 1'b1);
        bus.req = 4'b0000;
        @(negedge clk) lit("single_release", 4'b0000, 2'b10, 1'b0);

        // Full contention, each owner drops for one cycle after two grant cycles
        do_reset();
        bus.req = 4'b1111;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            r = 4'b0001 << (k % 4);
            lit("rr_order", r, 2'(k % 4), 1'b1);
            bus.req = 4'b1111;
            @(negedge clk);
            bus.req = 4'b1111 & ~r;
            @(negedge clk);
        end

        // Handoff 3 -> 0 on one edge, then pointer wrap decides 0 vs 1
        do_reset();
        bus.req = 4'b1000;
        @(negedge clk) lit("own3", 4'b1000, 2'b11, 1'b1);
        bus.req = 4'b0001;
        @(negedge clk) lit("handoff_3_to_0", 4'b0001, 2'b00, 1'b1);
        bus.req = 4'b0000;
        @(negedge clk) lit("idle_after_0", 4'b0000, 2'b00, 1'b0);
        bus.req = 4'b0011;
        @(negedge clk) lit("wrap_contest", 4'b0010, 2'b01, 1'b1);

        // Asynchronous reset between edges while gnt=0010
        #2 rst = 1'b1;
        #1 lit("async_reset", 4'b0000, 2'b00, 1'b0);
        @(negedge clk) bus.req = 4'b0011;
        @(negedge clk) rst = 1'b0;
        @(negedge clk) lit("post_reset", 4'b0001, 2'b00, 1'b1);

        // Non-owner activity must not disturb the owner
        bus.req = 4'b0001;
        @(negedge clk) bus.req = 4'b0111;
        @(negedge clk) bus.req = 4'b0101;
        @(negedge clk) bus.req = 4'b1101;
        @(negedge clk) lit("non_owner_noise", 4'b0001, 2'b00, 1'b1);
        bus.req = 4'b0000;
        repeat (2) @(negedge clk);

        // Constant req=0011 from reset
        @(negedge clk) rst = 1'b1;
        bus.req = 4'b0011;
        @(negedge clk) rst = 1'b0;
        @(negedge clk) lit("hold_start", 4'b0001, 2'b00, 1'b1);
`ifdef MUX_ARB_TIMEOUT_EN
        repeat (7) @(negedge clk);
        lit("hold_last_cycle0", 4'b0001, 2'b00, 1'b1);
        @(negedge clk) lit("forced_to_1", 4'b0010, 2'b01, 1'b1);
        repeat (7) @(negedge clk);
        lit("hold_last_cycle1", 4'b0010, 2'b01, 1'b1);
        @(negedge clk) lit("forced_to_0", 4'b0001, 2'b00, 1'b1);
        repeat (20) @(negedge clk);
`else
        repeat (100) @(negedge clk);
        lit("hold_100", 4'b0001, 2'b00, 1'b1);
`endif
        bus.req = 4'b0000;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter and select controller for the shared 4:1 multiplexer.
- Four requesters compete for the mux output. The block registers a one-hot grant and drives the mux select lines s1/s0 with the index of the current owner.
- Sits between the requester logic and the mux select inputs. It contains no data path.

Parameters:
- MAX_HOLD, 8: maximum consecutive cycles one owner may hold the grant. Used only when MUX_ARB_TIMEOUT_EN is defined. Legal range 2..2^CNT_W.
- CNT_W, 4: width of the hold counter.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  request vector; req[i] is requester i, level-sensitive.
- gnt  output 4  registered one-hot grant; all-zero when idle.
- s1   output 1  registered mux select MSB (owner index bit 1).
- s0   output 1  registered mux select LSB (owner index bit 0).
- busy output 1  registered; 1 while any grant is active.

Behaviour:
- Reset (async, immediate, also mid-grant):
  - state=IDLE, gnt=0000, s1=0, s0=0, busy=0.
  - Round-robin pointer ptr=0; hold counter=0.
- States: IDLE and GRANT.
- Selection function: the first i with req[i]=1, scanning ptr, ptr+1, ... modulo 4.
- IDLE:
  - If req==0000, stay; outputs hold (s1/s0 keep last owner index).
  - Else, on the edge: gnt=onehot(sel), {s1,s0}=sel, busy=1, ptr=sel+1 mod 4, go to GRANT.
  - Latency from req rise to gnt: 1 cycle.
- GRANT, owner o:
  - If req[o]=1 at the edge, hold gnt, s1/s0 and busy unchanged.
  - If req[o]=0 and other requests are pending, hand off on the same edge with no idle cycle: gnt, s1/s0 and ptr update to the next winner from the selection function; stay in GRANT.
  - If req[o]=0 and no other request is pending: gnt=0000, busy=0, go to IDLE. s1/s0 keep o.
- Grant and select always change on the same edge. gnt is never multi-hot; s1/s0 always equal the index of the set gnt bit when busy=1.
- Non-owner requests rising or falling during GRANT have no effect until the owner releases.
- Pointer wrap: ptr=3 grant sets ptr to 0.
- Simultaneous requests in IDLE are resolved purely by ptr order; there is no fixed priority.
- Hold counter:
  - Cleared on every new grant or handoff.
  - Increments each GRANT cycle while the owner holds.
  - Saturates at 2^CNT_W-1.

Optional Feature:
- Macro MUX_ARB_TIMEOUT_EN.
- Defined:
  - When the hold counter reaches MAX_HOLD-1 and the owner still requests, a forced rotation occurs on that edge if any other request is pending.
  - The forced rotation follows the handoff rules, with the current owner excluded from the scan.
  - If no other request is pending, the owner keeps the grant and the counter clears.
- Not defined:
  - No hold limit; the owner keeps the grant while req[o]=1.
  - Counter logic may be removed; MAX_HOLD is ignored.

Test Plan:
- Reset then req=0100 → after 1 clk: gnt=0100, s1=1, s0=0, busy=1. Drop req → next edge: gnt=0000, busy=0, s1s0 stay 10.
- After reset (ptr=0), req=1111 held, each owner drops its req for one cycle after 2 cycles of grant → grant order 0,1,2,3,0, with handoffs and no idle cycle between.
- Owner 3 granted, then req=0001 pending as 3 releases → gnt 1000→0001 on a single edge. Check ptr wrap: next contest between 0 and 1 goes to 1.
- Assert rst asynchronously mid-grant (gnt=0010) between clock edges → gnt=0000, s1s0=00, busy=0 immediately. After release, req=0011 → gnt=0001.
- MUX_ARB_TIMEOUT_EN, MAX_HOLD=8: req=0011 held constantly → owner 0 for 8 cycles, then forced to 1 for 8 cycles, alternating.
- Same stimulus with the macro undefined → owner 0 holds indefinitely (checked for 100 cycles).
